// File: rtl/pid_core_pipe_if.sv
// Handshake and data bundle between the sensor sample stream and pid_core_pipe.
// The master side drives samples, gains and clear; the slave side returns the control output.
interface pid_core_pipe_if #(
   parameter int DW = 16,
   parameter int GW = 16
);
   logic                 clear_i;
   logic signed [DW-1:0] setpoint_i;
   logic signed [DW-1:0] feedback_i;
   logic signed [GW-1:0] kp_i;
   logic signed [GW-1:0] ki_i;
   logic signed [GW-1:0] kd_i;
   logic                 sample_valid_i;
   logic                 sample_ready_o;
   logic signed [DW-1:0] control_out_o;
   logic                 out_valid_o;
   logic                 sat_flag_o;

   modport master (
      output clear_i, setpoint_i, feedback_i, kp_i, ki_i, kd_i, sample_valid_i,
      input  sample_ready_o, control_out_o, out_valid_o, sat_flag_o
   );

   modport slave (
      input  clear_i, setpoint_i, feedback_i, kp_i, ki_i, kd_i, sample_valid_i,
      output sample_ready_o, control_out_o, out_valid_o, sat_flag_o
   );
endinterface

// File: rtl/pid_core_pipe.sv
// Handshaked fixed-point PID controller: one shared signed multiplier, 5-cycle sequence, saturated output
// with anti-windup. Optional error deadband is enabled by defining PID_DEADBAND_EN.
module pid_core_pipe #(
   parameter int                       DW       = 16,
   parameter int                       GW       = 16,
   parameter int                       FRAC     = 8,
   parameter int                       IW       = 32,
   parameter logic signed [IW-1:0]     INT_LIM  = {1'b0, {(IW-1){1'b1}}},
   parameter int                       DEADBAND = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   pid_core_pipe_if.slave  bus
);

   localparam int AW = GW + IW + 2;
   localparam int BW = (IW > DW + 1) ? IW : DW + 1;
   localparam int PW = GW + BW;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ERR  = 3'd1;
   localparam logic [2:0] S_MULP = 3'd2;
   localparam logic [2:0] S_MULI = 3'd3;
   localparam logic [2:0] S_MULD = 3'd4;
   localparam logic [2:0] S_OUT  = 3'd5;

   localparam logic signed [DW-1:0] MAXV = {1'b0, {(DW-1){1'b1}}};
   localparam logic signed [DW-1:0] MINV = {1'b1, {(DW-1){1'b0}}};
   localparam logic signed [DW:0]   DB   = (DW+1)'(DEADBAND);

   logic [2:0]           state_q, state_d;
   logic signed [DW-1:0] sp_q, sp_d;
   logic signed [DW-1:0] fb_q, fb_d;
   logic signed [GW-1:0] kp_q, kp_d;
   logic signed [GW-1:0] ki_q, ki_d;
   logic signed [GW-1:0] kd_q, kd_d;
   logic signed [DW-1:0] err_q, err_d;
   logic signed [DW:0]   diff_q, diff_d;
   logic signed [DW-1:0] prevErr_q, prevErr_d;
   logic signed [IW-1:0] integ_q, integ_d;
   logic signed [AW-1:0] acc_q, acc_d;
   logic signed [DW-1:0] ctrl_q, ctrl_d;
   logic                 outValid_q, outValid_d;
   logic                 satFlag_q, satFlag_d;
   logic                 satNeg_q, satNeg_d;

   logic signed [DW:0]   errWide;
   logic signed [DW-1:0] errSat;
   logic signed [DW:0]   errExt;
   logic signed [DW-1:0] errEff;
   logic signed [DW:0]   diffWide;
   logic signed [IW:0]   integSum;
   logic signed [IW:0]   limExt;
   logic signed [IW-1:0] integClamp;
   logic                 windupHold;
   logic signed [GW-1:0] mulA;
   logic signed [BW-1:0] mulB;
   logic signed [PW-1:0] prod;
   logic signed [AW-1:0] prodExt;
   logic signed [AW-1:0] shifted;
   logic                 yHi, yLo;
   logic signed [DW-1:0] ySat;

   // Error path: widened subtraction, saturation back to DW, optional deadband, derivative and clamped integral.
   always_comb begin
      errWide = {sp_q[DW-1], sp_q} - {fb_q[DW-1], fb_q};
      errSat  = errWide[DW-1:0];
      if (errWide[DW] != errWide[DW-1]) begin
         errSat = errWide[DW] ? MINV : MAXV;
      end
      errExt = {errSat[DW-1], errSat};
`ifdef PID_DEADBAND_EN
      errEff = ((errExt <= DB) && (errExt >= -DB)) ? '0 : errSat;
`else
      errEff = errSat;
`endif
      diffWide   = {errEff[DW-1], errEff} - {prevErr_q[DW-1], prevErr_q};
      integSum   = {integ_q[IW-1], integ_q} + {{(IW+1-DW){errEff[DW-1]}}, errEff};
      limExt     = {INT_LIM[IW-1], INT_LIM};
      integClamp = integSum[IW-1:0];
      if (integSum > limExt) begin
         integClamp = INT_LIM;
      end else if (integSum < -limExt) begin
         integClamp = -INT_LIM;
      end
      // Freeze the integrator while the output is pinned and the error keeps pushing the same way.
      windupHold = satFlag_q && (errEff[DW-1] == satNeg_q);
   end

`ifndef PID_DEADBAND_EN
   // DEADBAND has no effect in this build; fold it into a dummy so it is still referenced.
   logic unusedDeadband;
   assign unusedDeadband = ^DB ^ ^errExt;
`endif

   // Shared multiplier: the operand pair is selected by the current multiply state.
   always_comb begin
      mulA = '0;
      mulB = '0;
      case (state_q)
         S_MULP: begin
            mulA = kp_q;
            mulB = BW'(err_q);
         end
         S_MULI: begin
            mulA = ki_q;
            mulB = BW'(integ_q);
         end
         S_MULD: begin
            mulA = kd_q;
            mulB = BW'(diff_q);
         end
         default: begin
            mulA = '0;
            mulB = '0;
         end
      endcase
      prod    = mulA * mulB;
      prodExt = AW'(prod);
   end

   // Output scaling: arithmetic shift rounds toward -inf, then clamp into the DW signed range.
   always_comb begin
      shifted = acc_q >>> FRAC;
      yHi     = shifted > AW'(MAXV);
      yLo     = shifted < AW'(MINV);
      ySat    = shifted[DW-1:0];
      if (yHi) begin
         ySat = MAXV;
      end else if (yLo) begin
         ySat = MINV;
      end
   end

   // Sequencer: IDLE -> ERR -> MUL_P -> MUL_I -> MUL_D -> OUT; clear overrides everything.
   always_comb begin
      state_d    = state_q;
      sp_d       = sp_q;
      fb_d       = fb_q;
      kp_d       = kp_q;
      ki_d       = ki_q;
      kd_d       = kd_q;
      err_d      = err_q;
      diff_d     = diff_q;
      prevErr_d  = prevErr_q;
      integ_d    = integ_q;
      acc_d      = acc_q;
      ctrl_d     = ctrl_q;
      outValid_d = 1'b0;
      satFlag_d  = satFlag_q;
      satNeg_d   = satNeg_q;
      case (state_q)
         S_IDLE: begin
            if (bus.sample_valid_i) begin
               sp_d    = bus.setpoint_i;
               fb_d    = bus.feedback_i;
               kp_d    = bus.kp_i;
               ki_d    = bus.ki_i;
               kd_d    = bus.kd_i;
               state_d = S_ERR;
            end
         end
         S_ERR: begin
            err_d     = errEff;
            diff_d    = diffWide;
            prevErr_d = errEff;
            if (!windupHold) begin
               integ_d = integClamp;
            end
            state_d = S_MULP;
         end
         S_MULP: begin
            acc_d   = prodExt;
            state_d = S_MULI;
         end
         S_MULI: begin
            acc_d   = acc_q + prodExt;
            state_d = S_MULD;
         end
         S_MULD: begin
            acc_d   = acc_q + prodExt;
            state_d = S_OUT;
         end
         S_OUT: begin
            ctrl_d     = ySat;
            satFlag_d  = yHi || yLo;
            satNeg_d   = (yHi || yLo) ? yLo : satNeg_q;
            outValid_d = 1'b1;
            state_d    = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (bus.clear_i) begin
         state_d    = S_IDLE;
         integ_d    = '0;
         prevErr_d  = '0;
         ctrl_d     = '0;
         satFlag_d  = 1'b0;
         outValid_d = 1'b0;
      end
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         sp_q       <= '0;
         fb_q       <= '0;
         kp_q       <= '0;
         ki_q       <= '0;
         kd_q       <= '0;
         err_q      <= '0;
         diff_q     <= '0;
         prevErr_q  <= '0;
         integ_q    <= '0;
         acc_q      <= '0;
         ctrl_q     <= '0;
         outValid_q <= 1'b0;
         satFlag_q  <= 1'b0;
         satNeg_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         sp_q       <= sp_d;
         fb_q       <= fb_d;
         kp_q       <= kp_d;
         ki_q       <= ki_d;
         kd_q       <= kd_d;
         err_q      <= err_d;
         diff_q     <= diff_d;
         prevErr_q  <= prevErr_d;
         integ_q    <= integ_d;
         acc_q      <= acc_d;
         ctrl_q     <= ctrl_d;
         outValid_q <= outValid_d;
         satFlag_q  <= satFlag_d;
         satNeg_q   <= satNeg_d;
      end
   end

   assign bus.sample_ready_o = (state_q == S_IDLE);
   assign bus.control_out_o  = ctrl_q;
   assign bus.out_valid_o    = outValid_q;
   assign bus.sat_flag_o     = satFlag_q;

endmodule
